// File: rtl/tcs_frequency_generator_if.sv
// rtl/tcs_frequency_generator_if.sv - select/load/output bundle between the colour-detection path and the emulated TCS3200 bar
interface tcs_frequency_generator_if;
  logic       load;
  logic [7:0] pattern;
  logic [3:0] sensorSelect;
  logic [1:0] colorSelect;
  logic       frequencyOut;
  logic       settled;
  logic [7:0] edgeCount;

  modport master (
    output load, pattern, sensorSelect, colorSelect,
    input  frequencyOut, settled, edgeCount
  );

  modport slave (
    input  load, pattern, sensorSelect, colorSelect,
    output frequencyOut, settled, edgeCount
  );
endinterface

// File: rtl/tcs_frequency_generator.sv
// rtl/tcs_frequency_generator.sv - four-sensor TCS3200 bar emulator producing a colour-dependent square wave
// Optional build macro TCS_NOISE_EN adds LFSR jitter of +/-1 clock to each loaded half-period.
module tcs_frequency_generator #(
  parameter int unsigned HALF_STRONG = 4,
  parameter int unsigned HALF_WEAK   = 16,
  parameter int unsigned HALF_CLEAR  = 3,
  parameter int unsigned SETTLE      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  tcs_frequency_generator_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam logic [7:0] HS = 8'(HALF_STRONG);
  localparam logic [7:0] HW = 8'(HALF_WEAK);
  localparam logic [7:0] HC = 8'(HALF_CLEAR);
  localparam logic [7:0] ST = 8'(SETTLE);

  state_e     state_q, state_d;
  logic       freq_q, freq_d;
  logic [7:0] edge_q, edge_d;
  logic [7:0] settle_q, settle_d;
  logic [7:0] half_q, half_d;
  logic [7:0] pattern_q;
  logic [3:0] prev_sel_q;
  logic [1:0] prev_col_q;

  logic       sel_valid;
  logic       restart;
  logic [1:0] sensor_idx;
  logic [1:0] colour;
  logic [7:0] half_nom;
  logic [7:0] half_load;
  logic [7:0] edge_inc;

  assign sel_valid = $onehot(bus.sensorSelect);
  assign restart   = (bus.sensorSelect != prev_sel_q) ||
                     (bus.colorSelect  != prev_col_q) || bus.load;
  assign edge_inc  = (edge_q == 8'hFF) ? 8'hFF : edge_q + 8'd1;

  always_comb begin
    sensor_idx = 2'd0;
    case (bus.sensorSelect)
      4'b0010: sensor_idx = 2'd1;
      4'b0100: sensor_idx = 2'd2;
      4'b1000: sensor_idx = 2'd3;
      default: sensor_idx = 2'd0;
    endcase
  end

  assign colour = pattern_q[{sensor_idx, 1'b0} +: 2];

  // Yellow reflects both red and green, so it reads strong under either filter.
  always_comb begin
    half_nom = HW;
    case (bus.colorSelect)
      2'b00:   half_nom = (colour == 2'd0 || colour == 2'd3) ? HS : HW;
      2'b11:   half_nom = (colour == 2'd1 || colour == 2'd3) ? HS : HW;
      2'b01:   half_nom = (colour == 2'd2) ? HS : HW;
      default: half_nom = HC;
    endcase
  end

`ifdef TCS_NOISE_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_comb begin
    half_load = half_nom;
    case (lfsr_q[1:0])
      2'b00:   half_load = (half_nom > 8'd1) ? half_nom - 8'd1 : 8'd1;
      2'b11:   half_load = half_nom + 8'd1;
      default: half_load = half_nom;
    endcase
  end
`else
  assign half_load = half_nom;
`endif

  always_comb begin
    state_d  = state_q;
    freq_d   = freq_q;
    edge_d   = edge_q;
    settle_d = settle_q;
    half_d   = half_q;
    if (!sel_valid) begin
      state_d = ST_IDLE;
      freq_d  = 1'b0;
      edge_d  = 8'd0;
    end else if (restart || state_q == ST_IDLE) begin
      state_d  = ST_SETTLE;
      settle_d = ST;
      freq_d   = 1'b0;
      edge_d   = 8'd0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_q <= 8'd1) begin
            state_d = ST_RUN;
            freq_d  = 1'b1;
            edge_d  = edge_inc;
            half_d  = half_load;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        ST_RUN: begin
          // H is sampled only here, so a mid-run change lands on the next toggle.
          if (half_q <= 8'd1) begin
            freq_d = ~freq_q;
            half_d = half_load;
            if (!freq_q) edge_d = edge_inc;
          end else begin
            half_d = half_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          freq_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      freq_q     <= 1'b0;
      edge_q     <= 8'd0;
      settle_q   <= 8'd0;
      half_q     <= 8'd0;
      pattern_q  <= 8'hE4;
      prev_sel_q <= 4'd0;
      prev_col_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      edge_q     <= edge_d;
      settle_q   <= settle_d;
      half_q     <= half_d;
      prev_sel_q <= bus.sensorSelect;
      prev_col_q <= bus.colorSelect;
      if (bus.load) pattern_q <= bus.pattern;
    end
  end

  assign bus.frequencyOut = freq_q;
  assign bus.settled      = (state_q == ST_RUN);
  assign bus.edgeCount    = edge_q;

endmodule

// File: tb/tb_tcs_frequency_generator.sv
// tb/tb_tcs_frequency_generator.sv - directed self-checking bench for tcs_frequency_generator
module tb_tcs_frequency_generator;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  int   n;

  tcs_frequency_generator_if bus ();

  tcs_frequency_generator #(
    .HALF_STRONG(4), .HALF_WEAK(16), .HALF_CLEAR(3), .SETTLE(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Clocks until the next 0->1 of frequencyOut; -1 if none within the budget.
  task automatic next_rise(output int cnt);
    logic p;
    p   = bus.frequencyOut;
    cnt = -1;
    for (int i = 1; i <= 100; i++) begin
      tick(1);
      if (!p && bus.frequencyOut) begin
        cnt = i;
        break;
      end
      p = bus.frequencyOut;
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.load         = 1'b0;
    bus.pattern      = 8'h00;
    bus.sensorSelect = 4'b0000;
    bus.colorSelect  = 2'b00;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_freq", bus.frequencyOut, 0);
    check("rst_settled", bus.settled, 0);
    check("rst_edges", bus.edgeCount, 0);
    check("rst_pattern", dut.pattern_q, 8'hE4);

    // sensor0 red under red filter: strong, period 8
    bus.sensorSelect = 4'b0001;
    bus.colorSelect  = 2'b00;
    tick(1);
    check("s0_e0_freq", bus.frequencyOut, 0);
    check("s0_e0_settled", bus.settled, 0);
    tick(1);
    check("s0_e1_freq", bus.frequencyOut, 0);
    tick(1);
    check("s0_e2_freq", bus.frequencyOut, 1);
    check("s0_e2_settled", bus.settled, 1);
    check("s0_e2_edges", bus.edgeCount, 1);
    tick(3);
    check("s0_e5_freq", bus.frequencyOut, 1);
    tick(1);
    check("s0_e6_freq", bus.frequencyOut, 0);
    next_rise(n);
    check("s0_rise2_gap", n, 4);
    check("s0_e10_edges", bus.edgeCount, 2);
    next_rise(n);
    check("s0_period", n, 8);
    check("s0_e18_edges", bus.edgeCount, 3);

    // sensor3 yellow: green filter strong, blue filter weak
    bus.sensorSelect = 4'b1000;
    bus.colorSelect  = 2'b11;
    next_rise(n);
    check("s3g_latency", n, 3);
    check("s3g_edges", bus.edgeCount, 1);
    next_rise(n);
    check("s3g_period", n, 8);
    bus.colorSelect = 2'b01;
    next_rise(n);
    check("s3b_latency", n, 3);
    next_rise(n);
    check("s3b_period", n, 32);

    // sensor0 mid-run switch to clear filter
    bus.sensorSelect = 4'b0001;
    bus.colorSelect  = 2'b00;
    next_rise(n);
    check("s0r_latency", n, 3);
    next_rise(n);
    check("s0r_period", n, 8);
    bus.colorSelect = 2'b10;
    tick(1);
    check("clr_e0_freq", bus.frequencyOut, 0);
    check("clr_e0_settled", bus.settled, 0);
    check("clr_e0_edges", bus.edgeCount, 0);
    tick(1);
    check("clr_e1_freq", bus.frequencyOut, 0);
    tick(1);
    check("clr_e2_freq", bus.frequencyOut, 1);
    check("clr_e2_edges", bus.edgeCount, 1);
    next_rise(n);
    check("clr_period", n, 6);

    // sensor2 blue under blue filter, then reload pattern to all red
    bus.sensorSelect = 4'b0100;
    bus.colorSelect  = 2'b01;
    next_rise(n);
    check("s2_latency", n, 3);
    next_rise(n);
    check("s2_period_before", n, 8);
    bus.load    = 1'b1;
    bus.pattern = 8'h00;
    tick(1);
    bus.load = 1'b0;
    check("ld_edges", bus.edgeCount, 0);
    check("ld_settled", bus.settled, 0);
    check("ld_pattern", dut.pattern_q, 8'h00);
    next_rise(n);
    check("ld_latency", n, 2);
    next_rise(n);
    check("s2_period_after", n, 32);

    // invalid selects hold the output low
    bus.sensorSelect = 4'b0011;
    tick(1);
    check("two_hot_freq", bus.frequencyOut, 0);
    check("two_hot_settled", bus.settled, 0);
    tick(4);
    check("two_hot_freq_hold", bus.frequencyOut, 0);
    check("two_hot_settled_hold", bus.settled, 0);
    bus.sensorSelect = 4'b0000;
    tick(5);
    check("zero_sel_freq", bus.frequencyOut, 0);
    check("zero_sel_settled", bus.settled, 0);
    bus.load    = 1'b1;
    bus.pattern = 8'h1B;
    tick(1);
    bus.load = 1'b0;
    check("ld_idle_pattern", dut.pattern_q, 8'h1B);
    check("ld_idle_settled", bus.settled, 0);
    tick(3);
    check("ld_idle_freq", bus.frequencyOut, 0);

    // sensor0 now yellow: red filter strong; then reset mid-run
    bus.sensorSelect = 4'b0001;
    bus.colorSelect  = 2'b00;
    next_rise(n);
    check("y0_latency", n, 3);
    next_rise(n);
    check("y0_period", n, 8);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("mid_rst_freq", bus.frequencyOut, 0);
    check("mid_rst_settled", bus.settled, 0);
    check("mid_rst_edges", bus.edgeCount, 0);
    check("mid_rst_pattern", dut.pattern_q, 8'hE4);
    reset = 1'b0;

    // clear filter, period 6: edge counter saturation
    bus.colorSelect = 2'b10;
    next_rise(n);
    check("sat_latency", n, 3);
    check("sat_first_edge", bus.edgeCount, 1);
    tick(594);
    check("sat_edge100_freq", bus.frequencyOut, 1);
    check("sat_edge100", bus.edgeCount, 100);
    tick(1200);
    check("sat_255", bus.edgeCount, 255);
    tick(30);
    check("sat_hold", bus.edgeCount, 255);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tcs_frequency_generator.md
# tcs_frequency_generator

Synthesizable model of the TCS3200 colour-sensor bar as seen from the FPGA: it takes the sensor-select and colour-filter-select lines that the colour-detection path drives and produces the sensor's square-wave frequency output. It emulates four sensors, each holding a programmable 2-bit cartridge colour. It is the far end of the colour-detection interface and is used for hardware-in-the-loop self-test and for simulation benches that replace the physical sensor bar.

## Interface
Parameters:
- HALF_STRONG, 4: output half-period in clocks when the selected filter matches the emulated colour (1..254).
- HALF_WEAK, 16: half-period when the filter does not match (1..254).
- HALF_CLEAR, 3: half-period for the clear (unfiltered) setting (1..254).
- SETTLE, 2: clocks the output is held low after any reselect or load (1..255).

Ports:
- clk  in  1  system clock (1 MHz domain).
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- load  in  1  single-cycle strobe; captures pattern.
- pattern  in  8  colour per sensor; sensor i is at [2i+1:2i]. Colour codes: 0 red, 1 green, 2 blue, 3 yellow.
- sensorSelect  in  4  one-hot sensor enable; bit i selects sensor i.
- colorSelect  in  2  filter select {S2,S3}: 00 red, 01 blue, 10 clear, 11 green.
- frequencyOut  out  1  registered square wave; this feeds frequencyFromColorSensor.
- settled  out  1  high while in RUN.
- edgeCount  out  8  rising edges since the last restart; saturates at 255.

## Operation
- Reset values:
  - pattern register = 8'b11_10_01_00 (sensor0 red, sensor1 green, sensor2 blue, sensor3 yellow).
  - state IDLE, frequencyOut 0, settled 0, edgeCount 0.
  - registered previous selects = 0.
- Half-period H for the active sensor colour c and filter f:
  - f=00: HALF_STRONG if c is 0 or 3, else HALF_WEAK.
  - f=11: HALF_STRONG if c is 1 or 3, else HALF_WEAK.
  - f=01: HALF_STRONG if c is 2, else HALF_WEAK.
  - f=10: HALF_CLEAR.
- States and transitions:
  - IDLE: output 0. Moves to SETTLE when sensorSelect is valid one-hot.
  - SETTLE: output 0, down-counter loaded with SETTLE. Moves to RUN when the counter expires.
  - RUN: toggles the output every H clocks.
- Restart event: on any edge where one of the following holds, the block enters SETTLE from any state, clears edgeCount and drives the output 0:
  - sensorSelect differs from its registered previous value,
  - colorSelect differs from its registered previous value,
  - load is high.
- Invalid select (zero bits or more than one bit set) → IDLE, regardless of load or other events.
- Load while sensorSelect is invalid: pattern is captured and the state stays IDLE.
- Half-period counter: 8 bits. H is re-evaluated at every toggle. Only restart events change H mid-run.

## Timing
- Restart sampled at edge E0: frequencyOut=0 and settled=0 after E0.
- RUN entry at edge E0+SETTLE: frequencyOut goes to 1, settled goes to 1, edgeCount becomes 1.
- First fall at E0+SETTLE+H. Next rise at E0+SETTLE+2H, where edgeCount becomes 2. Period = 2H clocks, 50% duty.
- Latency from a select change to the first rising edge: SETTLE+1 clocks counted from the input change.
- IDLE→SETTLE: entered on the edge at which a valid select is first sampled.
- Reset asserted mid-run: all outputs return to reset values on that edge, and the loaded pattern is lost.
- Reset has priority over load and restart events.
- edgeCount holds at 255. It does not wrap.

## Configuration
- TCS_NOISE_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every clock.
  - Each loaded half-period is adjusted by lfsr[1:0]: 00 → H-1, 11 → H+1, 01 or 10 → H.
  - The adjusted value is clamped to a minimum of 1.
- TCS_NOISE_EN undefined: no LFSR is built and every half-period is exactly H. All test-plan values assume it undefined.

## Test plan
- Reset, then sensorSelect=0001, colorSelect=00 at E0 → first rise at E0+2; output period 8 clocks; edgeCount=3 at E0+18.
- Sensor 3 (yellow), colorSelect=11 → period 8. Same sensor, colorSelect=01 → period 32.
- Mid-run colorSelect 00→10 on sensor 0 → output low for 2 clocks, then period 6; edgeCount restarts at 1.
- load with pattern=8'h00 while sensor 2 is selected with filter 01 → restart; period changes from 8 to 32.
- sensorSelect=0011, then 0000 → frequencyOut stays 0 and settled stays 0. Reset asserted mid-RUN → all outputs 0 on the next edge and pattern returns to 8'hE4.
- 300 rising edges without a restart → edgeCount saturates at 255.
